// File: rtl/rf_wb_arbiter_if.sv
// Writeback bus for rf_wb_arbiter: ALU and load requests, issue marking and the
// reg_file write port with scoreboard status.
interface rf_wb_arbiter_if #(
  parameter int unsigned DW   = 8,
  parameter int unsigned AW   = 4,
  parameter int unsigned NREG = 16
);
  logic            alu_valid;
  logic            alu_ready;
  logic [AW-1:0]   alu_addr;
  logic [DW-1:0]   alu_data;
  logic            mem_valid;
  logic            mem_ready;
  logic [AW-1:0]   mem_addr;
  logic [DW-1:0]   mem_data;
  logic            issue_valid;
  logic [AW-1:0]   issue_addr;
  logic            rf_write_en;
  logic [AW-1:0]   rf_wr_addr;
  logic [DW-1:0]   rf_val_in;
  logic [NREG-1:0] busy_mask;
  logic            init_done;
  logic            err_double;

  modport master (
    output alu_valid, alu_addr, alu_data,
    output mem_valid, mem_addr, mem_data,
    output issue_valid, issue_addr,
    input  alu_ready, mem_ready,
    input  rf_write_en, rf_wr_addr, rf_val_in,
    input  busy_mask, init_done, err_double
  );

  modport slave (
    input  alu_valid, alu_addr, alu_data,
    input  mem_valid, mem_addr, mem_data,
    input  issue_valid, issue_addr,
    output alu_ready, mem_ready,
    output rf_write_en, rf_wr_addr, rf_val_in,
    output busy_mask, init_done, err_double
  );
endinterface

// File: rtl/rf_wb_arbiter.sv
// Owns the reg_file write port: zero-fills after reset, then round-robins ALU and load
// writebacks through one-entry buffers and tracks pending writes per register.
module rf_wb_arbiter #(
  parameter int unsigned DW   = 8,
  parameter int unsigned AW   = 4,
  parameter int unsigned NREG = 16
) (
  input logic           clk,
  input logic           reset,
  rf_wb_arbiter_if.slave bus
);

  typedef enum logic {StInit, StRun} state_e;
  typedef enum logic {GrAlu, GrMem} src_e;

  state_e          state_q, state_d;
  logic [AW-1:0]   init_cnt_q, init_cnt_d;
  logic            alu_full_q, alu_full_d;
  logic [AW-1:0]   alu_addr_q, alu_addr_d;
  logic [DW-1:0]   alu_data_q, alu_data_d;
  logic            mem_full_q, mem_full_d;
  logic [AW-1:0]   mem_addr_q, mem_addr_d;
  logic [DW-1:0]   mem_data_q, mem_data_d;
  src_e            last_grant_q, last_grant_d;
  logic [NREG-1:0] busy_q, busy_d;
  logic            err_q, err_d;

  logic grant_alu, grant_mem;
  logic alu_ready, mem_ready;

  // Grant depends only on buffer occupancy; on a tie the source not served last wins.
  always_comb begin
    grant_alu = alu_full_q && (!mem_full_q || last_grant_q == GrMem);
    grant_mem = mem_full_q && (!alu_full_q || last_grant_q == GrAlu);
  end

  always_comb begin
    bus.rf_write_en = 1'b0;
    bus.rf_wr_addr  = '0;
    bus.rf_val_in   = '0;
    alu_ready       = 1'b0;
    mem_ready       = 1'b0;
    if (!reset) begin
      unique case (state_q)
        StInit: begin
          bus.rf_write_en = 1'b1;
          bus.rf_wr_addr  = init_cnt_q;
        end
        StRun: begin
          if (grant_alu) begin
            bus.rf_write_en = 1'b1;
            bus.rf_wr_addr  = alu_addr_q;
            bus.rf_val_in   = alu_data_q;
          end else if (grant_mem) begin
            bus.rf_write_en = 1'b1;
            bus.rf_wr_addr  = mem_addr_q;
            bus.rf_val_in   = mem_data_q;
          end
          alu_ready = !alu_full_q || grant_alu;
          mem_ready = !mem_full_q || grant_mem;
        end
        default: ;
      endcase
    end
    bus.alu_ready  = alu_ready;
    bus.mem_ready  = mem_ready;
    bus.init_done  = !reset && (state_q == StRun);
    bus.busy_mask  = busy_q;
    bus.err_double = err_q;
  end

  always_comb begin
    state_d      = state_q;
    init_cnt_d   = init_cnt_q;
    alu_full_d   = alu_full_q;
    alu_addr_d   = alu_addr_q;
    alu_data_d   = alu_data_q;
    mem_full_d   = mem_full_q;
    mem_addr_d   = mem_addr_q;
    mem_data_d   = mem_data_q;
    last_grant_d = last_grant_q;
    busy_d       = busy_q;
    err_d        = err_q;
    unique case (state_q)
      StInit: begin
        init_cnt_d = init_cnt_q + AW'(1);
        if (init_cnt_q == AW'(NREG - 1)) state_d = StRun;
      end
      StRun: begin
        if (grant_alu) begin
          alu_full_d           = 1'b0;
          last_grant_d         = GrAlu;
          busy_d[alu_addr_q]   = 1'b0;
        end
        if (grant_mem) begin
          mem_full_d           = 1'b0;
          last_grant_d         = GrMem;
          busy_d[mem_addr_q]   = 1'b0;
        end
        // Applied after the clear so a same-cycle issue keeps the bit set.
        if (bus.issue_valid) begin
          if (busy_q[bus.issue_addr]) err_d = 1'b1;
          busy_d[bus.issue_addr] = 1'b1;
        end
        if (bus.alu_valid && alu_ready) begin
          alu_full_d = 1'b1;
          alu_addr_d = bus.alu_addr;
          alu_data_d = bus.alu_data;
        end
        if (bus.mem_valid && mem_ready) begin
          mem_full_d = 1'b1;
          mem_addr_d = bus.mem_addr;
          mem_data_d = bus.mem_data;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= StInit;
      init_cnt_q   <= '0;
      alu_full_q   <= 1'b0;
      alu_addr_q   <= '0;
      alu_data_q   <= '0;
      mem_full_q   <= 1'b0;
      mem_addr_q   <= '0;
      mem_data_q   <= '0;
      last_grant_q <= GrMem;
      busy_q       <= '0;
      err_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      init_cnt_q   <= init_cnt_d;
      alu_full_q   <= alu_full_d;
      alu_addr_q   <= alu_addr_d;
      alu_data_q   <= alu_data_d;
      mem_full_q   <= mem_full_d;
      mem_addr_q   <= mem_addr_d;
      mem_data_q   <= mem_data_d;
      last_grant_q <= last_grant_d;
      busy_q       <= busy_d;
      err_q        <= err_d;
    end
  end

endmodule
